// File: rtl/priority_bit_streamer.sv
// Splits each accepted word into one beat per set bit, scanned LSB- or MSB-first.
// An all-zero word still produces a single beat flagged with bit_zero_o.
module priority_bit_streamer #(
  parameter int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             msb_first_i,
  input  logic             data_val_i,
  output logic             data_ready_o,
  output logic [WIDTH-1:0] bit_onehot_o,
  output logic [IDX_W-1:0] bit_idx_o,
  output logic [IDX_W-1:0] bit_cnt_o,
  output logic             bit_last_o,
  output logic             bit_zero_o,
  output logic             bit_val_o,
  input  logic             bit_ready_i
);

  // state | meaning
  // IDLE  | no beat pending, ready for a word
  // BUSY  | a beat is presented on bit_* (bit_val_o = 1)
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mask;
  logic             order_msb;
  logic             load, take, advance;
  logic [WIDTH-1:0] src, nxt_bit, nxt_mask;
  logic             src_msb;

  function automatic logic [WIDTH-1:0] pick_bit(input logic [WIDTH-1:0] m, input logic msb);
    logic [WIDTH-1:0] r;
    r = '0;
    if (msb) begin
      for (int i = 0; i < WIDTH; i++)
        if (m[i]) r = WIDTH'(1) << i;
    end else begin
      r = m & (~m + WIDTH'(1));
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] encode(input logic [WIDTH-1:0] oh);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++)
      if (oh[i]) r = r | IDX_W'(i);
    return r;
  endfunction

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load) state_nxt = BUSY;
      BUSY: if (take && bit_last_o) state_nxt = load ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bit_val_o    = (state == BUSY);
    data_ready_o = (state == IDLE) || (bit_val_o && bit_last_o && bit_ready_i);
    take         = bit_val_o && bit_ready_i;
    load         = data_val_i && data_ready_o;
    advance      = take && !bit_last_o;
  end

  // A new word and the held mask share one scan path; load and advance never coincide.
  always_comb begin
    src      = load ? data_i : mask;
    src_msb  = load ? msb_first_i : order_msb;
    nxt_bit  = pick_bit(src, src_msb);
    nxt_mask = src & ~nxt_bit;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      mask         <= '0;
      order_msb    <= 1'b0;
      bit_onehot_o <= '0;
      bit_idx_o    <= '0;
      bit_cnt_o    <= '0;
      bit_last_o   <= 1'b0;
      bit_zero_o   <= 1'b0;
    end else if (load || advance) begin
      mask         <= nxt_mask;
      bit_onehot_o <= nxt_bit;
      bit_idx_o    <= encode(nxt_bit);
      bit_last_o   <= (nxt_mask == '0);
      bit_cnt_o    <= load ? '0 : bit_cnt_o + IDX_W'(1);
      bit_zero_o   <= load && (data_i == '0);
      if (load) order_msb <= msb_first_i;
    end
  end

endmodule

// File: tb/tb_priority_bit_streamer.sv
// Self-checking bench for priority_bit_streamer (WIDTH=16): directed scenarios
// plus a randomized stream checked against a set-bit list model.
module tb_priority_bit_streamer;

  logic        clk_i = 1'b0;
  logic        arst_n_i;
  logic [15:0] data_i;
  logic        msb_first_i;
  logic        data_val_i;
  logic        data_ready_o;
  logic [15:0] bit_onehot_o;
  logic [3:0]  bit_idx_o;
  logic [3:0]  bit_cnt_o;
  logic        bit_last_o;
  logic        bit_zero_o;
  logic        bit_val_o;
  logic        bit_ready_i;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] oh;
    logic [3:0]  idx;
    logic [3:0]  cnt;
    logic        last;
    logic        zero;
  } beat_t;

  beat_t exp_q[$];

  priority_bit_streamer #(.WIDTH(16)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .data_i(data_i), .msb_first_i(msb_first_i),
    .data_val_i(data_val_i), .data_ready_o(data_ready_o), .bit_onehot_o(bit_onehot_o),
    .bit_idx_o(bit_idx_o), .bit_cnt_o(bit_cnt_o), .bit_last_o(bit_last_o),
    .bit_zero_o(bit_zero_o), .bit_val_o(bit_val_o), .bit_ready_i(bit_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference: list the set bit positions in scan order, then number them.
  function automatic void model_word(input logic [15:0] d, input logic m);
    int    pos[$];
    beat_t b;
    for (int p = 0; p < 16; p++) begin
      int i = m ? 15 - p : p;
      if (d[i]) pos.push_back(i);
    end
    if (pos.size() == 0) begin
      b.oh = '0; b.idx = '0; b.cnt = '0; b.last = 1'b1; b.zero = 1'b1;
      exp_q.push_back(b);
    end else begin
      for (int k = 0; k < pos.size(); k++) begin
        b.oh = '0;
        b.oh[pos[k]] = 1'b1;
        b.idx  = 4'(pos[k]);
        b.cnt  = 4'(k);
        b.last = (k == pos.size() - 1);
        b.zero = 1'b0;
        exp_q.push_back(b);
      end
    end
  endfunction

  task automatic test_reset();
    arst_n_i = 1'b0; data_i = '0; msb_first_i = 1'b0; data_val_i = 1'b0; bit_ready_i = 1'b1;
    #23;
    n_tests++;
    if ({bit_val_o, bit_onehot_o, bit_idx_o, bit_cnt_o, bit_last_o, bit_zero_o, data_ready_o}
        !== {1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1})
      begin n_fail++; $display("FAIL reset: val=%b oh=%h idx=%0d cnt=%0d last=%b zero=%b rdy=%b, want all 0 and rdy=1",
        bit_val_o, bit_onehot_o, bit_idx_o, bit_cnt_o, bit_last_o, bit_zero_o, data_ready_o); end
    @(negedge clk_i); arst_n_i = 1'b1;
  endtask

  task automatic test_single_word(input string name, input logic [15:0] d, input logic m);
    exp_q.delete();
    model_word(d, m);
    @(negedge clk_i); data_i = d; msb_first_i = m; data_val_i = 1'b1; bit_ready_i = 1'b1; #1;
    n_tests++;
    if (data_ready_o !== 1'b1) begin n_fail++; $display("FAIL %s idle_ready: got %b want 1", name, data_ready_o); end
    @(negedge clk_i); data_val_i = 1'b0; data_i = 16'($urandom); msb_first_i = 1'($urandom); #1;
    for (int k = 0; k < exp_q.size(); k++) begin
      n_tests++;
      if ({bit_val_o, bit_onehot_o, bit_idx_o, bit_cnt_o, bit_last_o, bit_zero_o}
          !== {1'b1, exp_q[k].oh, exp_q[k].idx, exp_q[k].cnt, exp_q[k].last, exp_q[k].zero})
        begin n_fail++; $display("FAIL %s beat%0d: val=%b oh=%h idx=%0d cnt=%0d last=%b zero=%b want oh=%h idx=%0d cnt=%0d last=%b zero=%b",
          name, k, bit_val_o, bit_onehot_o, bit_idx_o, bit_cnt_o, bit_last_o, bit_zero_o,
          exp_q[k].oh, exp_q[k].idx, exp_q[k].cnt, exp_q[k].last, exp_q[k].zero); end
      @(negedge clk_i); #1;
    end
    n_tests++;
    if ({bit_val_o, data_ready_o} !== 2'b01)
      begin n_fail++; $display("FAIL %s back_to_idle: val=%b rdy=%b want val=0 rdy=1", name, bit_val_o, data_ready_o); end
  endtask

  task automatic test_backpressure();
    exp_q.delete();
    model_word(16'hFFFF, 1'b0);
    @(negedge clk_i); data_i = 16'hFFFF; msb_first_i = 1'b0; data_val_i = 1'b1; bit_ready_i = 1'b1;
    @(negedge clk_i); data_val_i = 1'b0; #1;
    for (int k = 0; k < 16; k++) begin
      n_tests++;
      if ({bit_val_o, bit_onehot_o, bit_idx_o, bit_cnt_o, bit_last_o, bit_zero_o}
          !== {1'b1, exp_q[k].oh, exp_q[k].idx, exp_q[k].cnt, exp_q[k].last, exp_q[k].zero})
        begin n_fail++; $display("FAIL bp beat%0d: val=%b oh=%h idx=%0d cnt=%0d last=%b want oh=%h idx=%0d cnt=%0d last=%b",
          k, bit_val_o, bit_onehot_o, bit_idx_o, bit_cnt_o, bit_last_o,
          exp_q[k].oh, exp_q[k].idx, exp_q[k].cnt, exp_q[k].last); end
      if (k == 4) begin
        bit_ready_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk_i); #1;
          n_tests++;
          if ({bit_val_o, bit_onehot_o, bit_idx_o, bit_cnt_o, bit_last_o, data_ready_o}
              !== {1'b1, 16'h0010, 4'd4, 4'd4, 1'b0, 1'b0})
            begin n_fail++; $display("FAIL bp_hold%0d: val=%b oh=%h idx=%0d cnt=%0d last=%b rdy=%b want oh=0010 idx=4 cnt=4",
              s, bit_val_o, bit_onehot_o, bit_idx_o, bit_cnt_o, bit_last_o, data_ready_o); end
        end
        bit_ready_i = 1'b1;
      end
      @(negedge clk_i); #1;
    end
    n_tests++;
    if (bit_val_o !== 1'b0) begin n_fail++; $display("FAIL bp_end: val=%b want 0", bit_val_o); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i); data_i = 16'h0003; msb_first_i = 1'b0; data_val_i = 1'b1; bit_ready_i = 1'b1;
    @(negedge clk_i); #1;
    n_tests++;
    if ({bit_val_o, bit_onehot_o, bit_last_o, data_ready_o} !== {1'b1, 16'h0001, 1'b0, 1'b0})
      begin n_fail++; $display("FAIL b2b_first: val=%b oh=%h last=%b rdy=%b want oh=0001 last=0 rdy=0",
        bit_val_o, bit_onehot_o, bit_last_o, data_ready_o); end
    data_i = 16'h0100;
    @(negedge clk_i); #1;
    n_tests++;
    if ({bit_val_o, bit_onehot_o, bit_cnt_o, bit_last_o, data_ready_o} !== {1'b1, 16'h0002, 4'd1, 1'b1, 1'b1})
      begin n_fail++; $display("FAIL b2b_second: val=%b oh=%h cnt=%0d last=%b rdy=%b want oh=0002 cnt=1 last=1 rdy=1",
        bit_val_o, bit_onehot_o, bit_cnt_o, bit_last_o, data_ready_o); end
    @(negedge clk_i); data_val_i = 1'b0; #1;
    n_tests++;
    if ({bit_val_o, bit_onehot_o, bit_idx_o, bit_cnt_o, bit_last_o} !== {1'b1, 16'h0100, 4'd8, 4'd0, 1'b1})
      begin n_fail++; $display("FAIL b2b_next_word: val=%b oh=%h idx=%0d cnt=%0d last=%b want oh=0100 idx=8 cnt=0 last=1",
        bit_val_o, bit_onehot_o, bit_idx_o, bit_cnt_o, bit_last_o); end
    @(negedge clk_i); #1;
    n_tests++;
    if (bit_val_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: val=%b want 0", bit_val_o); end
  endtask

  task automatic test_reset_mid_word();
    @(negedge clk_i); data_i = 16'h00F0; msb_first_i = 1'b0; data_val_i = 1'b1; bit_ready_i = 1'b1;
    @(negedge clk_i); data_val_i = 1'b0;
    @(negedge clk_i); #1;
    n_tests++;
    if ({bit_val_o, bit_onehot_o, bit_cnt_o} !== {1'b1, 16'h0020, 4'd1})
      begin n_fail++; $display("FAIL rst_mid_pre: val=%b oh=%h cnt=%0d want oh=0020 cnt=1", bit_val_o, bit_onehot_o, bit_cnt_o); end
    #2 arst_n_i = 1'b0;
    #1;
    n_tests++;
    if ({bit_val_o, bit_onehot_o, bit_idx_o, bit_cnt_o, bit_last_o, bit_zero_o, data_ready_o}
        !== {1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1})
      begin n_fail++; $display("FAIL rst_mid_async: val=%b oh=%h idx=%0d cnt=%0d last=%b zero=%b rdy=%b want all 0 rdy=1",
        bit_val_o, bit_onehot_o, bit_idx_o, bit_cnt_o, bit_last_o, bit_zero_o, data_ready_o); end
    @(negedge clk_i); @(negedge clk_i); arst_n_i = 1'b1;
    test_single_word("post_reset", 16'h0001, 1'b0);
  endtask

  task automatic test_random();
    int    sent = 0;
    int    cyc  = 0;
    bit    acc  = 1'b0;
    logic  exp_rdy;
    exp_q.delete();
    while ((sent < 150 || exp_q.size() != 0) && cyc < 20000) begin
      @(negedge clk_i);
      cyc++;
      if (acc) data_val_i = 1'b0;
      acc = 1'b0;
      if (!data_val_i && sent < 150 && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 3))
          0:       data_i = 16'h0000;
          1:       data_i = 16'h0001 << $urandom_range(0, 15);
          2:       data_i = 16'($urandom);
          default: data_i = 16'($urandom) & 16'($urandom) & 16'($urandom);
        endcase
        msb_first_i = 1'($urandom);
        data_val_i  = 1'b1;
      end
      bit_ready_i = ($urandom_range(0, 9) < 7);
      #1;
      exp_rdy = (exp_q.size() == 0) || (bit_ready_i && exp_q[0].last);
      n_tests++;
      if ({bit_val_o, data_ready_o} !== {exp_q.size() != 0, exp_rdy})
        begin n_fail++; $display("FAIL rand_hs cyc%0d: val=%b rdy=%b want val=%b rdy=%b",
          cyc, bit_val_o, data_ready_o, exp_q.size() != 0, exp_rdy); end
      if (exp_q.size() != 0) begin
        n_tests++;
        if ({bit_onehot_o, bit_idx_o, bit_cnt_o, bit_last_o, bit_zero_o}
            !== {exp_q[0].oh, exp_q[0].idx, exp_q[0].cnt, exp_q[0].last, exp_q[0].zero})
          begin n_fail++; $display("FAIL rand_beat cyc%0d: oh=%h idx=%0d cnt=%0d last=%b zero=%b want oh=%h idx=%0d cnt=%0d last=%b zero=%b",
            cyc, bit_onehot_o, bit_idx_o, bit_cnt_o, bit_last_o, bit_zero_o,
            exp_q[0].oh, exp_q[0].idx, exp_q[0].cnt, exp_q[0].last, exp_q[0].zero); end
        if (bit_ready_i) void'(exp_q.pop_front());
      end
      if (data_val_i && exp_rdy) begin
        model_word(data_i, msb_first_i);
        sent++;
        acc = 1'b1;
      end
    end
    @(negedge clk_i); data_val_i = 1'b0; bit_ready_i = 1'b1;
    n_tests++;
    if (cyc >= 20000) begin n_fail++; $display("FAIL rand_timeout: sent=%0d pending=%0d want all drained", sent, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_word("zero_word", 16'h0000, 1'b0);
    test_single_word("lsb_first", 16'h8421, 1'b0);
    test_single_word("msb_first", 16'h8421, 1'b1);
    test_single_word("msb_zero", 16'h0000, 1'b1);
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
